// File: rtl/ltl_monitor_engine.sv
// ltl_monitor_engine: run-time programmable homogeneous NFA monitor evaluating one LTL property over a symbol stream
module ltl_monitor_engine #(
  parameter int N_STATES = 16,
  parameter int SYM_W = 8,
  parameter int N_TERMS = 4,
  parameter int CNT_W = 16,
  localparam int IW = $clog2(N_STATES),
  localparam int TW = N_TERMS > 1 ? $clog2(N_TERMS) : 1,
  localparam int FW = N_TERMS + 3,
  localparam int DW = 2 * SYM_W > N_STATES ? (2 * SYM_W > FW ? 2 * SYM_W : FW) : (N_STATES > FW ? N_STATES : FW)
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                run,
  input  logic                clear,
  input  logic [SYM_W-1:0]    symbols,
  input  logic                cfg_we,
  input  logic [1:0]          cfg_kind,
  input  logic [IW-1:0]       cfg_state,
  input  logic [TW-1:0]       cfg_term,
  input  logic [DW-1:0]       cfg_wdata,
  output logic                cfg_err,
  output logic [N_STATES-1:0] report,
  output logic                report_any,
  output logic [CNT_W-1:0]    report_count,
  output logic [CNT_W-1:0]    first_idx,
  output logic [CNT_W-1:0]    sym_count
);
  localparam logic [CNT_W-1:0] cnt_max = '1;
  logic [2*SYM_W-1:0] term_q [N_STATES][N_TERMS];
  logic [FW-1:0] flag_q [N_STATES];
  logic [N_STATES-1:0] adj_q [N_STATES];
  logic [N_STATES-1:0] act_q, act_d, match, rep_v;
  logic sod_q, upd_q, err_q, any_q, cfg_bad, cfg_ok, term_ok;
  logic [CNT_W-1:0] rcnt_q, first_q, sym_q;
  // flag layout: {term_en[N_TERMS-1:0], rep, all, sod}
  always_comb begin
    match = '0;
    rep_v = '0;
    act_d = '0;
    for (int s = 0; s < N_STATES; s++) begin
      for (int t = 0; t < N_TERMS; t++)
        match[s] = match[s] | (flag_q[s][3+t] & ((symbols & term_q[s][t][2*SYM_W-1:SYM_W]) == (term_q[s][t][SYM_W-1:0] & term_q[s][t][2*SYM_W-1:SYM_W])));
      rep_v[s] = flag_q[s][2];
      act_d[s] = match[s] & (|(act_q & adj_q[s]) | (flag_q[s][0] & sod_q) | flag_q[s][1]);
    end
  end
  assign cfg_bad = cfg_we & (run | cfg_kind == 2'd3 | {1'b0, cfg_state} >= (IW+1)'(N_STATES));
  assign cfg_ok = cfg_we & ~cfg_bad;
  assign term_ok = {1'b0, cfg_term} < (TW+1)'(N_TERMS);
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      for (int s = 0; s < N_STATES; s++) begin
        flag_q[s] <= '0;
        adj_q[s] <= '0;
        for (int t = 0; t < N_TERMS; t++) term_q[s][t] <= '0;
      end
    end else if (cfg_ok) begin
      if (cfg_kind == 2'd0 && term_ok) term_q[cfg_state][cfg_term] <= cfg_wdata[2*SYM_W-1:0];
      if (cfg_kind == 2'd1) adj_q[cfg_state] <= cfg_wdata[N_STATES-1:0];
      if (cfg_kind == 2'd2) flag_q[cfg_state] <= cfg_wdata[FW-1:0];
    end
  end
  // upd_q marks that report reflects a freshly consumed symbol, so it is counted exactly once
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      act_q <= '0;
      sod_q <= 1'b1;
      upd_q <= 1'b0;
      err_q <= 1'b0;
      any_q <= 1'b0;
      rcnt_q <= '0;
      first_q <= '0;
      sym_q <= '0;
    end else begin
      err_q <= cfg_bad;
      if (clear) begin
        act_q <= '0;
        sod_q <= 1'b1;
        upd_q <= 1'b0;
        any_q <= 1'b0;
        rcnt_q <= '0;
        first_q <= '0;
        sym_q <= '0;
      end else begin
        upd_q <= run;
        if (upd_q && |report) begin
          if (rcnt_q != cnt_max) rcnt_q <= rcnt_q + CNT_W'(1);
          if (!any_q) begin
            any_q <= 1'b1;
            first_q <= sym_q - CNT_W'(1);
          end
        end
        if (run) begin
          act_q <= act_d;
          sod_q <= 1'b0;
          if (sym_q != cnt_max) sym_q <= sym_q + CNT_W'(1);
        end
      end
    end
  end
  assign report = act_q & rep_v;
  assign cfg_err = err_q;
  assign report_any = any_q;
  assign report_count = rcnt_q;
  assign first_idx = first_q;
  assign sym_count = sym_q;
endmodule

// File: tb/tb_ltl_monitor_engine.sv
// tb_ltl_monitor_engine: directed stimulus against a set-based NFA model, two instances with wide and 4-bit counters
module tb_ltl_monitor_engine;
  logic clk = 0, reset_n = 0, run = 0, clear = 0, cfg_we = 0;
  logic [7:0] symbols = '0;
  logic [1:0] cfg_kind = '0, cfg_term = '0;
  logic [3:0] cfg_state = '0;
  logic [15:0] cfg_wdata = '0;
  logic err_a, err_b, any_a, any_b;
  logic [15:0] rep_a, rep_b, rc_a, fi_a, sc_a;
  logic [3:0] rc_b, fi_b, sc_b;
  int n_chk = 0, n_err = 0;
  ltl_monitor_engine #(.N_STATES(16), .SYM_W(8), .N_TERMS(4), .CNT_W(16)) dut_a (
    .clk(clk), .reset_n(reset_n), .run(run), .clear(clear), .symbols(symbols),
    .cfg_we(cfg_we), .cfg_kind(cfg_kind), .cfg_state(cfg_state), .cfg_term(cfg_term), .cfg_wdata(cfg_wdata),
    .cfg_err(err_a), .report(rep_a), .report_any(any_a), .report_count(rc_a), .first_idx(fi_a), .sym_count(sc_a));
  ltl_monitor_engine #(.N_STATES(16), .SYM_W(8), .N_TERMS(4), .CNT_W(4)) dut_b (
    .clk(clk), .reset_n(reset_n), .run(run), .clear(clear), .symbols(symbols),
    .cfg_we(cfg_we), .cfg_kind(cfg_kind), .cfg_state(cfg_state), .cfg_term(cfg_term), .cfg_wdata(cfg_wdata),
    .cfg_err(err_b), .report(rep_b), .report_any(any_b), .report_count(rc_b), .first_idx(fi_b), .sym_count(sc_b));
  always #5 clk = ~clk;
  // model: configuration as plain arrays, active set as a bit per state, counters as ints
  int m_mask[16][4], m_val[16][4];
  bit m_en[16][4], m_adj[16][16];
  bit m_sod[16], m_all[16], m_rep[16], m_act[16], nxt[16];
  bit m_start, m_pend, m_err, started, rep_now, hit, pred;
  bit m_any[2];
  int m_rc[2], m_fi[2], m_sc[2];
  int cap[2] = '{65535, 15};
  always @(posedge clk) begin
    started = 1;
    if (!reset_n) begin
      for (int s = 0; s < 16; s++) begin
        m_sod[s] = 0; m_all[s] = 0; m_rep[s] = 0; m_act[s] = 0;
        for (int t = 0; t < 4; t++) begin m_mask[s][t] = 0; m_val[s][t] = 0; m_en[s][t] = 0; end
        for (int p = 0; p < 16; p++) m_adj[s][p] = 0;
      end
      m_start = 1; m_pend = 0; m_err = 0;
      for (int i = 0; i < 2; i++) begin m_any[i] = 0; m_rc[i] = 0; m_fi[i] = 0; m_sc[i] = 0; end
    end else begin
      m_err = cfg_we && (run || cfg_kind == 2'd3);
      if (clear) begin
        for (int s = 0; s < 16; s++) m_act[s] = 0;
        m_start = 1; m_pend = 0;
        for (int i = 0; i < 2; i++) begin m_any[i] = 0; m_rc[i] = 0; m_fi[i] = 0; m_sc[i] = 0; end
      end else begin
        rep_now = 0;
        for (int s = 0; s < 16; s++) if (m_act[s] && m_rep[s]) rep_now = 1;
        if (m_pend && rep_now)
          for (int i = 0; i < 2; i++) begin
            if (!m_any[i]) begin m_any[i] = 1; m_fi[i] = m_sc[i] - 1; end
            if (m_rc[i] < cap[i]) m_rc[i]++;
          end
        if (run) begin
          for (int s = 0; s < 16; s++) begin
            hit = 0; pred = 0;
            for (int t = 0; t < 4; t++) if (m_en[s][t] && ((int'(symbols) ^ m_val[s][t]) & m_mask[s][t]) == 0) hit = 1;
            for (int p = 0; p < 16; p++) if (m_act[p] && m_adj[s][p]) pred = 1;
            nxt[s] = hit && (pred || (m_sod[s] && m_start) || m_all[s]);
          end
          m_act = nxt;
          m_start = 0;
          for (int i = 0; i < 2; i++) if (m_sc[i] < cap[i]) m_sc[i]++;
          m_pend = 1;
        end else m_pend = 0;
      end
      if (cfg_we && !m_err) begin
        if (cfg_kind == 2'd0) begin m_mask[cfg_state][cfg_term] = cfg_wdata[15:8]; m_val[cfg_state][cfg_term] = cfg_wdata[7:0]; end
        if (cfg_kind == 2'd1) for (int p = 0; p < 16; p++) m_adj[cfg_state][p] = cfg_wdata[p];
        if (cfg_kind == 2'd2) begin
          m_sod[cfg_state] = cfg_wdata[0]; m_all[cfg_state] = cfg_wdata[1]; m_rep[cfg_state] = cfg_wdata[2];
          for (int t = 0; t < 4; t++) m_en[cfg_state][t] = cfg_wdata[3+t];
        end
      end
    end
  end
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask
  always @(negedge clk) begin
    logic [15:0] exp_rep;
    if (started) begin
      exp_rep = '0;
      for (int s = 0; s < 16; s++) exp_rep[s] = m_act[s] & m_rep[s];
      chk("report_a", rep_a, exp_rep);
      chk("report_b", rep_b, exp_rep);
      chk("cfg_err_a", err_a, m_err);
      chk("cfg_err_b", err_b, m_err);
      chk("report_any_a", any_a, m_any[0]);
      chk("report_any_b", any_b, m_any[1]);
      chk("report_count_a", rc_a, m_rc[0]);
      chk("report_count_b", rc_b, m_rc[1]);
      chk("first_idx_a", fi_a, m_fi[0]);
      chk("first_idx_b", fi_b, m_fi[1]);
      chk("sym_count_a", sc_a, m_sc[0]);
      chk("sym_count_b", sc_b, m_sc[1]);
    end
  end
  task automatic tick(input bit r, input bit c, input logic [7:0] s);
    run = r; clear = c; symbols = s;
    @(negedge clk);
    run = 0; clear = 0;
  endtask
  task automatic wr(input logic [1:0] k, input logic [3:0] st, input logic [1:0] t, input logic [15:0] d, input bit r);
    cfg_we = 1; cfg_kind = k; cfg_state = st; cfg_term = t; cfg_wdata = d; run = r;
    @(negedge clk);
    cfg_we = 0; run = 0;
  endtask
  task automatic do_reset();
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
  endtask
  initial begin
    repeat (2) @(negedge clk);
    reset_n = 1;
    chk("lit_reset_sym", sc_a, 0);
    chk("lit_reset_rep", rep_a, 0);
    for (int i = 0; i < 256; i++) tick(1, 0, 8'(i));
    tick(0, 0, 0);
    chk("lit_zero_cfg_sym_a", sc_a, 256);
    chk("lit_zero_cfg_sym_b", sc_b, 15);
    chk("lit_zero_cfg_any", any_a, 0);
    do_reset();
    wr(2'd0, 4'd0, 2'd0, 16'hFF2A, 0);
    wr(2'd2, 4'd0, 2'd0, 16'h000D, 0);
    tick(1, 0, 8'h2A);
    chk("lit_sod_report", rep_a, 16'h0001);
    tick(0, 0, 0);
    chk("lit_sod_count", rc_a, 1);
    chk("lit_sod_first", fi_a, 0);
    tick(0, 1, 0);
    tick(1, 0, 8'h00);
    tick(1, 0, 8'h2A);
    tick(0, 0, 0);
    chk("lit_sod_late_any", any_a, 0);
    do_reset();
    wr(2'd0, 4'd0, 2'd0, 16'h2800, 0);
    wr(2'd2, 4'd0, 2'd0, 16'h0009, 0);
    wr(2'd0, 4'd1, 2'd0, 16'h0808, 0);
    wr(2'd1, 4'd1, 2'd0, 16'h0001, 0);
    wr(2'd2, 4'd1, 2'd0, 16'h0008, 0);
    wr(2'd0, 4'd2, 2'd0, 16'h0000, 0);
    wr(2'd1, 4'd2, 2'd0, 16'h0002, 0);
    wr(2'd2, 4'd2, 2'd0, 16'h000C, 0);
    wr(2'd1, 4'd2, 2'd0, 16'h0000, 1);
    chk("lit_err_run", err_a, 1);
    wr(2'd3, 4'd0, 2'd0, 16'h0000, 0);
    chk("lit_err_kind3", err_a, 1);
    tick(1, 0, 8'h01);
    chk("lit_err_pulse_end", err_a, 0);
    tick(1, 0, 8'h0C);
    tick(0, 1, 0);
    chk("lit_clear_sym", sc_a, 0);
    tick(1, 0, 8'h01);
    tick(1, 0, 8'h0C);
    tick(1, 0, 8'h55);
    chk("lit_chain_report", rep_a, 16'h0004);
    tick(1, 0, 8'h55);
    chk("lit_chain_no_loop", rep_a, 0);
    tick(0, 0, 0);
    chk("lit_chain_first", fi_a, 2);
    chk("lit_chain_count", rc_a, 1);
    do_reset();
    wr(2'd0, 4'd3, 2'd0, 16'h2020, 0);
    wr(2'd2, 4'd3, 2'd0, 16'h000E, 0);
    repeat (5) tick(1, 0, 8'h20);
    chk("lit_all_report", rep_a, 16'h0008);
    tick(0, 0, 0);
    chk("lit_all_count", rc_a, 5);
    chk("lit_all_first", fi_a, 0);
    tick(0, 1, 0);
    repeat (20) tick(1, 0, 8'h20);
    tick(0, 0, 0);
    chk("lit_sat_sym_b", sc_b, 15);
    chk("lit_sat_count_b", rc_b, 15);
    chk("lit_sat_first_b", fi_b, 0);
    chk("lit_sat_sym_a", sc_a, 20);
    chk("lit_sat_count_a", rc_a, 20);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule

// File: doc/ltl_monitor_engine.md
# ltl_monitor_engine

Programmable, parameterised homogeneous-automaton runtime monitor. It evaluates one LTL property per instance over a stream of SYM_W-bit event symbols produced by the core's trace tap. It replaces the per-property, hard-wired cluster automata in the monitor hierarchy. Match classes, transitions and start/report attributes are loaded at run time through a configuration port, so one netlist serves every property cluster. It also adds sticky verdict, report counting and first-violation index capture.

## Interface
- N_STATES, 16: number of automaton states (STEs), 2..64.
- SYM_W, 8: symbol width, 1..16.
- N_TERMS, 4: mask/value match terms per state, 1..8.
- CNT_W, 16: width of symbol index and report counters.
- DW (localparam): max(2*SYM_W, N_STATES, N_TERMS+3). IW (localparam): clog2(N_STATES).

Ports:
- clk  in  1  rising-edge clock.
- reset_n  in  1  synchronous, active-low reset.
- run  in  1  symbol valid / advance enable.
- clear  in  1  restart the monitor; configuration is kept.
- symbols  in  SYM_W  event symbol.
- cfg_we  in  1  configuration write strobe.
- cfg_kind  in  2  0 = term, 1 = adjacency row, 2 = flags.
- cfg_state  in  IW  target state.
- cfg_term  in  clog2(N_TERMS)  term index, used when kind = 0.
- cfg_wdata  in  DW  write data.
- cfg_err  out  1  one-cycle pulse on a rejected write.
- report  out  N_STATES  active & report_mask, per state.
- report_any  out  1  sticky: any report since reset or clear.
- report_count  out  CNT_W  saturating count of cycles with any report bit set.
- first_idx  out  CNT_W  symbol index that produced the first report.
- sym_count  out  CNT_W  saturating count of consumed symbols.

## Operation
- Configuration registers per state s:
  - term[s][t] = {mask, value}.
  - term_en[s].
  - sod[s]: start-of-data start.
  - all[s]: all-input start.
  - rep[s]: report state.
  - adj[s]: N_STATES-bit predecessor row. Bit p set means edge p→s.
- Write encoding:
  - kind 0: cfg_wdata[2*SYM_W-1:0] = {mask, value}.
  - kind 1: cfg_wdata[N_STATES-1:0] = predecessor row.
  - kind 2: cfg_wdata[N_TERMS+2:0] = {term_en, rep, all, sod}.
  - kind 3: reserved. A kind 3 write is rejected.
- Writes apply only when run = 0. A write with run = 1, cfg_state ≥ N_STATES or kind 3 is dropped, and cfg_err pulses the next cycle.
- Symbol match: match[s] = OR over enabled t of ((symbols & mask) == (value & mask)). A state with no enabled terms never matches. mask = 0 with the term enabled matches every symbol.
- start_of_data is internal. It is 1 on the first run cycle after reset or clear, then 0.
- Update on each cycle with run = 1:
  - active'[s] = match[s] & (|(active & adj[s]) | (sod[s] & start_of_data) | all[s]).
- run = 0 holds all state and counters.
- report = active & rep, combinational from the active register.
- When |report = 1:
  - report_count increments (saturating).
  - If report_any is 0: report_any sets and first_idx captures sym_count − 1, the index of the symbol that caused it.
- sym_count increments on every run cycle and saturates at all-ones.
- clear (run ignored that cycle):
  - Zeroes active, report_any, report_count, first_idx and sym_count.
  - Re-arms start_of_data.
  - Configuration is unchanged.
- Reset clears all configuration to zero, which gives no matches.

## Timing
- Reset values: every output is 0, cfg_err is 0, active is 0, start_of_data is armed.
- Latency:
  - A symbol sampled at edge k shows up in report after edge k.
  - report_count, report_any and first_idx update at edge k+1.
- Priority, highest first: reset_n = 0, then clear, then run update. A config write in the same cycle as clear is accepted if run = 0.
- reset_n deasserts mid-stream: the first run cycle afterwards is start-of-data.
- Counter saturation: at all-ones, sym_count holds and first_idx captures all-ones minus 1. report_count holds.
- Self-loops (adj[s][s]) and multiple simultaneous active states are legal. The automaton is a nondeterministic finite automaton (NFA), not a DFA.
- A config write takes effect on the next run cycle. No write can land mid-run.

## Test plan
- Reset, then run with all configuration zero and symbols 0x00..0xFF: report = 0, report_any = 0, sym_count = 256.
- State 0 configured as sod with term {mask 0xFF, value 0x2A}, rep = 1. Feed 0x2A first: report[0] = 1 one cycle later, first_idx = 0, report_count = 1. Feed 0x2A second instead: no report.
- Chain 0→1→2 with 0 sod, terms (mask 0x28 / value 0x00), (0x08/0x08), (0x00/0x00), rep on 2. Feed 0x01, 0x0C, 0x55: report[2] = 1 after the third symbol, first_idx = 2. A further 0x55 gives report = 0, since state 2 has no self-loop.
- all = 1 on a state with term 0x20/0x20, rep = 1, and five symbols 0x20: report_count = 5, first_idx = 0.
- cfg_we with run = 1: cfg_err pulses once and the adjacency read-back behaviour is unchanged. clear mid-stream: counters reach 0 and the next symbol is treated as start-of-data.
- With CNT_W = 4, run 20 symbols with report every cycle: sym_count = 15 and report_count = 15 (both saturated), first_idx = 0.
